obi_outstanding_limiter: RTL and testbench
==========================================

Name: obi_outstanding_limiter

Overview:
- Single-channel OBI stage placed directly downstream of a crossbar manager port, in front of the subordinate or its relOBI decoder.
- Caps in-flight transactions at MaxTrans.
- Records each granted request ID in order and checks every response ID against it, since OBI responses return in order.
- Raises pulse and sticky fault flags for ID mismatches and for unexpected responses.

Parameters:
AddrWidth, 32, address width
DataWidth, 32, data width; BE width is DataWidth/8
IdWidth, 8, aid/rid width
MaxTrans, 8, maximum outstanding transactions (>=1)
UseRReady, 0, 1: r handshake is rvalid&&rready; 0: rready treated as constant 1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
clear_i  in  1  synchronous clear of sticky_err_o
sbr_req_i  in  1  upstream request
sbr_gnt_o  out  1  upstream grant
sbr_addr_i  in  AddrWidth  address
sbr_we_i  in  1  write enable
sbr_be_i  in  DataWidth/8  byte enables
sbr_wdata_i  in  DataWidth  write data
sbr_aid_i  in  IdWidth  request ID
sbr_rvalid_o  out  1  response valid
sbr_rready_i  in  1  response ready (ignored if UseRReady=0)
sbr_rdata_o  out  DataWidth  read data
sbr_rid_o  out  IdWidth  response ID
sbr_err_o  out  1  response error
mgr_req_o  out  1  downstream request
mgr_gnt_i  in  1  downstream grant
mgr_addr_o/we_o/be_o/wdata_o/aid_o  out  as sbr side  forwarded A channel
mgr_rvalid_i  in  1  downstream response valid
mgr_rready_o  out  1  downstream response ready
mgr_rdata_i/rid_i/err_i  in  as sbr side  downstream R channel
outstanding_o  out  $clog2(MaxTrans+1)  current in-flight count
busy_o  out  1  outstanding_o != 0
id_err_o  out  1  one-cycle pulse on rid mismatch
unexpected_rsp_o  out  1  one-cycle pulse on response with count 0
sticky_err_o  out  1  OR of all pulses since reset/clear

Behaviour:
- Reset (while rst_n=1, async) state:
  - cnt = 0, ID FIFO empty.
  - id_err_o = 0, unexpected_rsp_o = 0, sticky_err_o = 0.
  - mgr_req_o = 0 and sbr_gnt_o = 0 as soon as reset asserts.
- Reset mid-operation discards all tracking. Any response arriving after reset releases is flagged unexpected.
- Admission:
  - space = (cnt < MaxTrans).
  - mgr_req_o = sbr_req_i && space.
  - sbr_gnt_o = mgr_gnt_i && space.
  - A-channel fields pass through combinationally; zero added latency.
  - No same-cycle credit from a retiring response: at cnt==MaxTrans, req is blocked even if a response retires in that cycle.
- A handshake: a_hs = mgr_req_o && mgr_gnt_i. On a_hs, cnt += 1 and sbr_aid_i is pushed into the ID FIFO.
- R path:
  - Passes through combinationally; mgr_rready_o = sbr_rready_i.
  - r_hs = mgr_rvalid_i && (UseRReady ? sbr_rready_i : 1).
- Valid response (r_hs with cnt > 0):
  - cnt -= 1 and the FIFO pops.
  - If popped ID != mgr_rid_i, id_err_o = 1 for the next cycle and sticky_err_o is set.
  - The response is still forwarded unchanged.
- Unexpected response (r_hs with cnt == 0): no decrement, no pop, unexpected_rsp_o pulses next cycle, sticky is set, and the response is still forwarded.
- a_hs and r_hs in the same cycle: cnt unchanged; FIFO push and pop both occur, and an empty-FIFO pop is treated as the unexpected case.
- A-to-R in one cycle:
  - A response may arrive in the cycle after its a_hs, but never in the same cycle (OBI non-CombGnt).
  - A same-cycle rvalid with cnt==0 counts as unexpected.
- Sticky flag:
  - clear_i clears sticky_err_o next cycle.
  - A new error pulse in the same cycle as clear_i wins, so sticky stays 1.
- cnt never exceeds MaxTrans and never wraps below 0.

Decomposition:
- Shared obi_pkg additions:
  - obi_limiter_status_t struct {outstanding, busy, id_err, unexpected_rsp, sticky_err}.
  - Function cnt_width(MaxTrans) = $clog2(MaxTrans+1).
- Sub-module: obi_id_fifo, a plain depth-MaxTrans, width-IdWidth FIFO with push/pop/empty/full/head. Its full flag must equal cnt==MaxTrans; an assertion checks this.
- Top level: counter, admission gating, ID compare and flag registers.

Test Plan:
- MaxTrans=2, subordinate withholds responses, manager issues 3 reqs (aid 1,2,3) → 2 granted, outstanding_o=2, third held (mgr_req_o=0). After response rid=1 retires, third granted the following cycle.
- Back-to-back req each cycle, response one cycle after each grant → one grant per cycle sustained, outstanding_o stays 1, no flags.
- Grant aid=5 then aid=6, subordinate returns rid=6 first → id_err_o pulses once and sticky_err_o=1. Response still forwarded with rid=6, outstanding_o goes to 1.
- With cnt=0, inject mgr_rvalid_i=1 → unexpected_rsp_o pulses, outstanding_o stays 0. Then clear_i=1 → sticky_err_o=0 next cycle.
- UseRReady=1, rvalid held 3 cycles with rready=0 then 1 → cnt decrements exactly once, only in the rready cycle.
- Assert rst_n=1 with outstanding_o=3 → all outputs 0 immediately. Release reset, inject response → unexpected_rsp_o pulses.

Source files
------------

// File: rtl/obi_outstanding_limiter_pkg.sv
// Shared types and helpers for the OBI outstanding-transaction limiter.
//   obi_limiter_status_t : snapshot of the limiter status outputs
//   cnt_width()          : width of a counter that can hold 0..max_trans
package obi_outstanding_limiter_pkg;

    // Wide enough for any practical MaxTrans; users slice down to cnt_width().
    localparam int unsigned CNT_W_MAX = 16;

    typedef struct packed {
        logic [CNT_W_MAX-1:0] outstanding;
        logic                 busy;
        logic                 id_err;
        logic                 unexpected_rsp;
        logic                 sticky_err;
    } obi_limiter_status_t;

    function automatic int unsigned cnt_width(input int unsigned max_trans);
        return $clog2(max_trans + 1);
    endfunction

endpackage

// File: rtl/obi_outstanding_limiter_id_fifo.sv
// Plain ring-buffer FIFO holding the IDs of granted requests in issue order.
// Ports:
//   clk, rst_n      clock, asynchronous active-high reset
//   push, data_in   write side
//   pop             read side (advances head)
//   head            oldest entry (valid when !empty)
//   empty, full     occupancy flags
module obi_outstanding_limiter_id_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] data_in,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CntW'(Depth));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_outstanding_limiter.sv
// Single-channel OBI stage that caps in-flight transactions at MaxTrans and
// checks that in-order responses carry the ID of the oldest granted request.
// Ports:
//   clk, rst_n, clear_i          clock, async active-high reset, sticky clear
//   sbr_*                        upstream (manager-facing) OBI port
//   mgr_*                        downstream (subordinate-facing) OBI port
//   outstanding_o, busy_o        in-flight count and count != 0
//   id_err_o, unexpected_rsp_o   one-cycle pulses after the offending response
//   sticky_err_o                 OR of all pulses since reset/clear
module obi_outstanding_limiter
    import obi_outstanding_limiter_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 8,
    parameter int unsigned MaxTrans  = 8,
    parameter int unsigned UseRReady = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_i,
    input  logic                             sbr_req_i,
    output logic                             sbr_gnt_o,
    input  logic [AddrWidth-1:0]             sbr_addr_i,
    input  logic                             sbr_we_i,
    input  logic [DataWidth/8-1:0]           sbr_be_i,
    input  logic [DataWidth-1:0]             sbr_wdata_i,
    input  logic [IdWidth-1:0]               sbr_aid_i,
    output logic                             sbr_rvalid_o,
    input  logic                             sbr_rready_i,
    output logic [DataWidth-1:0]             sbr_rdata_o,
    output logic [IdWidth-1:0]               sbr_rid_o,
    output logic                             sbr_err_o,
    output logic                             mgr_req_o,
    input  logic                             mgr_gnt_i,
    output logic [AddrWidth-1:0]             mgr_addr_o,
    output logic                             mgr_we_o,
    output logic [DataWidth/8-1:0]           mgr_be_o,
    output logic [DataWidth-1:0]             mgr_wdata_o,
    output logic [IdWidth-1:0]               mgr_aid_o,
    input  logic                             mgr_rvalid_i,
    output logic                             mgr_rready_o,
    input  logic [DataWidth-1:0]             mgr_rdata_i,
    input  logic [IdWidth-1:0]               mgr_rid_i,
    input  logic                             mgr_err_i,
    output logic [cnt_width(MaxTrans)-1:0]   outstanding_o,
    output logic                             busy_o,
    output logic                             id_err_o,
    output logic                             unexpected_rsp_o,
    output logic                             sticky_err_o
);
    localparam int unsigned     CntW   = cnt_width(MaxTrans);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

    logic [CntW-1:0]    cnt;
    logic               space, a_hs, r_hs, rsp_ok, rsp_unexp, id_mismatch;
    logic               id_err_q, unexp_q, sticky_q;
    logic [IdWidth-1:0] fifo_head;
    logic               fifo_empty, fifo_full;

    // Admission uses only the registered count: a response retiring this
    // cycle does not open a slot until the next one. The reset term forces
    // req/gnt low the instant reset asserts, not at the next edge.
    assign space     = (cnt < CntMax);
    assign mgr_req_o = sbr_req_i && space && !rst_n;
    assign sbr_gnt_o = mgr_gnt_i && space && !rst_n;
    assign a_hs      = mgr_req_o && mgr_gnt_i;

    assign mgr_addr_o  = sbr_addr_i;
    assign mgr_we_o    = sbr_we_i;
    assign mgr_be_o    = sbr_be_i;
    assign mgr_wdata_o = sbr_wdata_i;
    assign mgr_aid_o   = sbr_aid_i;

    assign sbr_rvalid_o = mgr_rvalid_i;
    assign sbr_rdata_o  = mgr_rdata_i;
    assign sbr_rid_o    = mgr_rid_i;
    assign sbr_err_o    = mgr_err_i;
    assign mgr_rready_o = sbr_rready_i;

    assign r_hs        = mgr_rvalid_i && ((UseRReady != 0) ? sbr_rready_i : 1'b1);
    // A response with nothing tracked is never matched, even if a request is
    // being granted in the same cycle.
    assign rsp_ok      = r_hs && (cnt != '0);
    assign rsp_unexp   = r_hs && (cnt == '0);
    assign id_mismatch = rsp_ok && (fifo_head != mgr_rid_i);

    obi_outstanding_limiter_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdWidth)
    ) i_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (a_hs),
        .data_in (sbr_aid_i),
        .pop     (rsp_ok),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt      <= '0;
            id_err_q <= 1'b0;
            unexp_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            case ({a_hs, rsp_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            id_err_q <= id_mismatch;
            unexp_q  <= rsp_unexp;
            // A fresh error outranks a simultaneous clear.
            if (id_mismatch || rsp_unexp) sticky_q <= 1'b1;
            else if (clear_i)             sticky_q <= 1'b0;
        end
    end

    assign outstanding_o    = cnt;
    assign busy_o           = (cnt != '0);
    assign id_err_o         = id_err_q;
    assign unexpected_rsp_o = unexp_q;
    assign sticky_err_o     = sticky_q;

`ifndef SYNTHESIS
    // The ID FIFO and the counter track the same thing and must agree.
    assert property (@(posedge clk) disable iff (rst_n) fifo_full == (cnt == CntMax));
    assert property (@(posedge clk) disable iff (rst_n) fifo_empty == (cnt == '0));
`endif

endmodule

// File: tb/tb_obi_outstanding_limiter.sv
module tb_obi_outstanding_limiter;
    import obi_outstanding_limiter_pkg::*;

    localparam int MT = 3;
    localparam int CW = cnt_width(MT);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          clear_i = 0, sbr_req_i = 0, sbr_we_i = 0, sbr_rready_i = 0;
    logic [31:0]   sbr_addr_i = 0, sbr_wdata_i = 0, mgr_rdata_i = 0;
    logic [3:0]    sbr_be_i = 0;
    logic [7:0]    sbr_aid_i = 0, mgr_rid_i = 0;
    logic          mgr_gnt_i = 0, mgr_rvalid_i = 0, mgr_err_i = 0;
    logic          sbr_gnt_o, sbr_rvalid_o, sbr_err_o, mgr_req_o, mgr_we_o, mgr_rready_o;
    logic [31:0]   sbr_rdata_o, mgr_addr_o, mgr_wdata_o;
    logic [7:0]    sbr_rid_o, mgr_aid_o;
    logic [3:0]    mgr_be_o;
    logic [CW-1:0] outstanding_o;
    logic          busy_o, id_err_o, unexpected_rsp_o, sticky_err_o;

    obi_outstanding_limiter #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(8), .MaxTrans(MT), .UseRReady(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
        .sbr_req_i(sbr_req_i), .sbr_gnt_o(sbr_gnt_o), .sbr_addr_i(sbr_addr_i),
        .sbr_we_i(sbr_we_i), .sbr_be_i(sbr_be_i), .sbr_wdata_i(sbr_wdata_i),
        .sbr_aid_i(sbr_aid_i), .sbr_rvalid_o(sbr_rvalid_o), .sbr_rready_i(sbr_rready_i),
        .sbr_rdata_o(sbr_rdata_o), .sbr_rid_o(sbr_rid_o), .sbr_err_o(sbr_err_o),
        .mgr_req_o(mgr_req_o), .mgr_gnt_i(mgr_gnt_i), .mgr_addr_o(mgr_addr_o),
        .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
        .mgr_aid_o(mgr_aid_o), .mgr_rvalid_i(mgr_rvalid_i), .mgr_rready_o(mgr_rready_o),
        .mgr_rdata_i(mgr_rdata_i), .mgr_rid_i(mgr_rid_i), .mgr_err_i(mgr_err_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o), .id_err_o(id_err_o),
        .unexpected_rsp_o(unexpected_rsp_o), .sticky_err_o(sticky_err_o)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       req;
        logic [7:0] aid;
        logic       gnt, rv, rr;
        logic [7:0] rid;
        logic       clr;
        logic       e_req, e_gnt;
        int         e_out;
        logic       e_iderr, e_unexp, e_sticky;
    } vec_t;

    vec_t                vecs[$];
    obi_limiter_status_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic req, input logic [7:0] aid, input logic gnt, input logic rv,
                       input logic rr, input logic [7:0] rid, input logic clr,
                       input logic e_req, input logic e_gnt, input int e_out,
                       input logic e_iderr, input logic e_unexp, input logic e_sticky);
        vec_t v;
        v.req = req; v.aid = aid; v.gnt = gnt; v.rv = rv; v.rr = rr; v.rid = rid; v.clr = clr;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_out = e_out;
        v.e_iderr = e_iderr; v.e_unexp = e_unexp; v.e_sticky = e_sticky;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive inputs, check combinational paths, queue the
    // expected registered status, then compare it after the edge.
    task automatic step(input vec_t v);
        obi_limiter_status_t s, got;
        sbr_req_i = v.req;  sbr_aid_i = v.aid;  mgr_gnt_i = v.gnt;
        mgr_rvalid_i = v.rv; sbr_rready_i = v.rr; mgr_rid_i = v.rid; clear_i = v.clr;
        sbr_addr_i = $urandom; sbr_wdata_i = $urandom; sbr_be_i = 4'($urandom);
        sbr_we_i = 1'($urandom); mgr_rdata_i = $urandom; mgr_err_i = 1'($urandom);
        #1;
        chk("mgr_req", 32'(mgr_req_o), 32'(v.e_req));
        chk("sbr_gnt", 32'(sbr_gnt_o), 32'(v.e_gnt));
        chk("a_pass", 32'(mgr_addr_o == sbr_addr_i && mgr_aid_o == v.aid && mgr_wdata_o == sbr_wdata_i
                          && mgr_be_o == sbr_be_i && mgr_we_o == sbr_we_i), 32'd1);
        chk("r_pass", 32'(sbr_rvalid_o == v.rv && sbr_rid_o == v.rid && sbr_rdata_o == mgr_rdata_i
                          && sbr_err_o == mgr_err_i && mgr_rready_o == v.rr), 32'd1);
        s.outstanding    = 16'(v.e_out);
        s.busy           = (v.e_out != 0);
        s.id_err         = v.e_iderr;
        s.unexpected_rsp = v.e_unexp;
        s.sticky_err     = v.e_sticky;
        exp_q.push_back(s);
        @(posedge clk);
        #1;
        got.outstanding    = 16'(outstanding_o);
        got.busy           = busy_o;
        got.id_err         = id_err_o;
        got.unexpected_rsp = unexpected_rsp_o;
        got.sticky_err     = sticky_err_o;
        s = exp_q.pop_front();
        chk("outstanding", 32'(got.outstanding), 32'(s.outstanding));
        chk("busy", 32'(got.busy), 32'(s.busy));
        chk("id_err", 32'(got.id_err), 32'(s.id_err));
        chk("unexpected_rsp", 32'(got.unexpected_rsp), 32'(s.unexpected_rsp));
        chk("sticky_err", 32'(got.sticky_err), 32'(s.sticky_err));
    endtask

    task automatic step_args(input logic req, input logic [7:0] aid, input logic gnt, input logic rv,
                             input logic rr, input logic [7:0] rid, input logic clr,
                             input logic e_req, input logic e_gnt, input int e_out,
                             input logic e_iderr, input logic e_unexp, input logic e_sticky);
        vec_t v;
        v.req = req; v.aid = aid; v.gnt = gnt; v.rv = rv; v.rr = rr; v.rid = rid; v.clr = clr;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_out = e_out;
        v.e_iderr = e_iderr; v.e_unexp = e_unexp; v.e_sticky = e_sticky;
        step(v);
    endtask

    initial begin
        int          m_cnt;
        logic [7:0]  m_q[$];
        logic        m_sticky;

        // Directed table: cap, back-to-back, ID mismatch, unexpected+clear,
        // rready stall, error-beats-clear, same-cycle A/R with cnt 0.
        //  req aid  gnt rv rr rid  clr | e_req e_gnt out iderr unexp sticky
        add(1, 1,  1, 0, 0, 0,  0,  1, 1, 1, 0, 0, 0);
        add(1, 2,  1, 0, 0, 0,  0,  1, 1, 2, 0, 0, 0);
        add(1, 3,  1, 0, 0, 0,  0,  1, 1, 3, 0, 0, 0);
        add(1, 4,  1, 0, 0, 0,  0,  0, 0, 3, 0, 0, 0);
        add(1, 4,  1, 1, 1, 1,  0,  0, 0, 2, 0, 0, 0);
        add(1, 4,  1, 0, 0, 0,  0,  1, 1, 3, 0, 0, 0);
        add(0, 0,  0, 1, 1, 2,  0,  0, 0, 2, 0, 0, 0);
        add(0, 0,  0, 1, 1, 3,  0,  0, 0, 1, 0, 0, 0);
        add(0, 0,  0, 1, 1, 4,  0,  0, 0, 0, 0, 0, 0);
        add(1, 10, 1, 0, 0, 0,  0,  1, 1, 1, 0, 0, 0);
        add(1, 11, 1, 1, 1, 10, 0,  1, 1, 1, 0, 0, 0);
        add(1, 12, 1, 1, 1, 11, 0,  1, 1, 1, 0, 0, 0);
        add(0, 0,  0, 1, 1, 12, 0,  0, 0, 0, 0, 0, 0);
        add(1, 5,  1, 0, 0, 0,  0,  1, 1, 1, 0, 0, 0);
        add(1, 6,  1, 0, 0, 0,  0,  1, 1, 2, 0, 0, 0);
        add(0, 0,  0, 1, 1, 6,  0,  0, 0, 1, 1, 0, 1);
        add(0, 0,  0, 0, 0, 0,  0,  0, 0, 1, 0, 0, 1);
        add(0, 0,  0, 1, 1, 6,  0,  0, 0, 0, 0, 0, 1);
        add(0, 0,  0, 1, 1, 9,  0,  0, 0, 0, 0, 1, 1);
        add(0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 1);
        add(0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0);
        add(0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
        add(1, 7,  1, 0, 0, 0,  0,  1, 1, 1, 0, 0, 0);
        add(0, 0,  0, 1, 0, 7,  0,  0, 0, 1, 0, 0, 0);
        add(0, 0,  0, 1, 0, 7,  0,  0, 0, 1, 0, 0, 0);
        add(0, 0,  0, 1, 0, 7,  0,  0, 0, 1, 0, 0, 0);
        add(0, 0,  0, 1, 1, 7,  0,  0, 0, 0, 0, 0, 0);
        add(0, 0,  0, 1, 1, 3,  1,  0, 0, 0, 0, 1, 1);
        add(0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0);
        add(1, 8,  1, 1, 1, 8,  0,  1, 1, 1, 0, 1, 1);
        add(0, 0,  0, 1, 1, 8,  0,  0, 0, 0, 0, 0, 1);
        add(0, 0,  0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 0);

        // Reset state, with a request pending to show the gating.
        sbr_req_i = 1; mgr_gnt_i = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mgr_req", 32'(mgr_req_o), 32'd0);
        chk("rst_sbr_gnt", 32'(sbr_gnt_o), 32'd0);
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_flags", {28'd0, busy_o, id_err_o, unexpected_rsp_o, sticky_err_o}, 32'd0);
        sbr_req_i = 0; mgr_gnt_i = 0;
        rst_n = 0;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Reset in the middle of traffic with three outstanding and sticky set.
        step_args(1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        step_args(1, 2, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0);
        step_args(0, 0, 0, 1, 1, 9, 0, 0, 0, 1, 1, 0, 1);
        step_args(1, 3, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1);
        step_args(1, 4, 1, 0, 0, 0, 0, 1, 1, 3, 0, 0, 1);
        sbr_req_i = 1; mgr_gnt_i = 1; mgr_rvalid_i = 0;
        #2;
        rst_n = 1;
        #1;
        chk("midrst_mgr_req", 32'(mgr_req_o), 32'd0);
        chk("midrst_sbr_gnt", 32'(sbr_gnt_o), 32'd0);
        chk("midrst_outstanding", 32'(outstanding_o), 32'd0);
        chk("midrst_flags", {28'd0, busy_o, id_err_o, unexpected_rsp_o, sticky_err_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 0;
        step_args(0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 1);

        // Randomised traffic against a reference model of the spec.
        m_cnt = 0;
        m_sticky = 1;
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            logic ahs, rhs, ok, ue, ie;
            v.req = ($urandom_range(0, 9) < 6);
            v.gnt = ($urandom_range(0, 9) < 7);
            v.rv  = ($urandom_range(0, 9) < 4);
            v.rr  = ($urandom_range(0, 9) < 8);
            v.clr = ($urandom_range(0, 9) == 0);
            v.aid = 8'($urandom);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) v.rid = m_q[0];
            else                                             v.rid = 8'($urandom);
            v.e_req = v.req && (m_cnt < MT);
            v.e_gnt = v.gnt && (m_cnt < MT);
            ahs = v.e_req && v.gnt;
            rhs = v.rv && v.rr;
            ok  = rhs && (m_cnt > 0);
            ue  = rhs && (m_cnt == 0);
            ie  = ok && (m_q[0] != v.rid);
            if (ok)  void'(m_q.pop_front());
            if (ahs) m_q.push_back(v.aid);
            m_cnt = m_cnt + int'(ahs) - int'(ok);
            if (ie || ue)   m_sticky = 1;
            else if (v.clr) m_sticky = 0;
            v.e_out = m_cnt; v.e_iderr = ie; v.e_unexp = ue; v.e_sticky = m_sticky;
            step(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
